// File: rtl/exu_alu_disp.sv
// ALU dispatch buffer: a 2-entry FIFO between dispatch and commit, with an
// ebreak/trap halt controller and a count of committed ops.
module exu_alu_disp #(
  parameter int PC_SIZE    = 32,
  parameter int INSTR_SIZE = 32,
  parameter int XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  disp_i_valid,
  output logic                  disp_i_ready,
  input  logic [PC_SIZE-1:0]    disp_i_pc,
  input  logic [INSTR_SIZE-1:0] disp_i_instr,
  input  logic [XLEN-1:0]       disp_i_imm,
  input  logic                  disp_i_pc_vld,
  input  logic                  disp_i_ebreak,

  output logic                  alu_cmt_o_valid,
  input  logic                  alu_cmt_o_ready,
  output logic [PC_SIZE-1:0]    alu_cmt_o_pc,
  output logic [INSTR_SIZE-1:0] alu_cmt_o_instr,
  output logic [XLEN-1:0]       alu_cmt_o_imm,
  output logic                  alu_cmt_o_pc_vld,
  output logic                  alu_cmt_o_ebreak,

  input  logic                  commit_trap,
  output logic                  disp_halted,
  output logic [1:0]            buf_cnt,
  output logic [XLEN-1:0]       cmt_cnt
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    EBRK_WAIT = 2'd1,
    HALT      = 2'd2
  } state_t;

  typedef struct packed {
    logic [PC_SIZE-1:0]    pc;
    logic [INSTR_SIZE-1:0] instr;
    logic [XLEN-1:0]       imm;
    logic                  pc_vld;
    logic                  ebreak;
  } entry_t;

  state_t          state_q;
  state_t          state_d;
  entry_t          mem [2];
  entry_t          wr_entry;
  entry_t          rd_entry;
  logic            wr_ptr_q;
  logic            rd_ptr_q;
  logic [1:0]      cnt_q;
  logic [XLEN-1:0] cmt_cnt_q;
  logic            push;
  logic            pop;

  // Handshakes are masked while reset is held so nothing moves in that cycle.
  assign disp_i_ready    = rst && (state_q == RUN) && (cnt_q != 2'd2);
  assign alu_cmt_o_valid = rst && (cnt_q != 2'd0) && (state_q != HALT);
  assign push            = disp_i_valid && disp_i_ready;
  assign pop             = alu_cmt_o_valid && alu_cmt_o_ready;

  assign wr_entry = '{pc:     disp_i_pc,
                      instr:  disp_i_instr,
                      imm:    disp_i_imm,
                      pc_vld: disp_i_pc_vld,
                      ebreak: disp_i_ebreak};

  assign rd_entry         = mem[rd_ptr_q];
  assign alu_cmt_o_pc     = rd_entry.pc;
  assign alu_cmt_o_instr  = rd_entry.instr;
  assign alu_cmt_o_imm    = rd_entry.imm;
  assign alu_cmt_o_pc_vld = rd_entry.pc_vld;
  assign alu_cmt_o_ebreak = rd_entry.ebreak;

  assign disp_halted = (state_q == HALT);
  assign buf_cnt     = cnt_q;
  assign cmt_cnt     = cmt_cnt_q;

  // NOTE: default assigned first so every path through the case drives state_d (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (commit_trap)                  state_d = HALT;
        else if (push && disp_i_ebreak)   state_d = EBRK_WAIT;
      end
      EBRK_WAIT: begin
        if (commit_trap) state_d = HALT;
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= RUN;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
      cmt_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
      if (pop) cmt_cnt_q <= cmt_cnt_q + XLEN'(1);
    end
  end

  // NOTE: storage is not reset; occupancy and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_entry;
  end

endmodule

// File: doc/exu_alu_disp.md
EXU_ALU_DISP -- requirements
Module: exu_alu_disp

Interface
Parameters (name, default, meaning):
REQ-001 SHALL define PC_SIZE, 32, PC width.
REQ-002 SHALL define INSTR_SIZE, 32, instruction width.
REQ-003 SHALL define XLEN, 32, immediate and counter width.

Ports (name, direction, width, meaning):
REQ-004 SHALL provide clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL provide rst, input, 1, synchronous active-low reset, sampled on clk rising edge.
REQ-006 SHALL provide disp_i_valid, input, 1, upstream ALU op valid.
REQ-007 SHALL provide disp_i_ready, output, 1, block accepts op this cycle.
REQ-008 SHALL provide disp_i_pc / disp_i_instr / disp_i_imm, input, PC_SIZE / INSTR_SIZE / XLEN, op payload.
REQ-009 SHALL provide disp_i_pc_vld / disp_i_ebreak, input, 1 each, redirect-PC flag and decoded ebreak flag.
REQ-010 SHALL provide alu_cmt_o_valid, output, 1, commit-bound entry valid.
REQ-011 SHALL provide alu_cmt_o_ready, input, 1, commit accepts entry.
REQ-012 SHALL provide alu_cmt_o_pc / alu_cmt_o_instr / alu_cmt_o_imm / alu_cmt_o_pc_vld / alu_cmt_o_ebreak, output, matching payload widths, head-entry payload.
REQ-013 SHALL provide commit_trap, input, 1, commit-side trap indication.
REQ-014 SHALL provide disp_halted, output, 1, block is in HALT.
REQ-015 SHALL provide buf_cnt, output, 2, occupancy, 0..2.
REQ-016 SHALL provide cmt_cnt, output, XLEN, count of completed output handshakes.

Function
REQ-017 SHALL buffer ops in a 2-entry FIFO with 1-bit read/write pointers that wrap 1->0.
REQ-018 SHALL push on disp_i_valid && disp_i_ready and pop on alu_cmt_o_valid && alu_cmt_o_ready.
REQ-019 SHALL have no combinational path from the disp_i_* inputs to alu_cmt_o_*; an op pushed into an empty FIFO in cycle N appears on the output in cycle N+1.
REQ-020 SHALL hold alu_cmt_o_* payload stable while alu_cmt_o_valid=1 and alu_cmt_o_ready=0.
REQ-021 SHALL drive disp_i_ready = (state==RUN) && (buf_cnt!=2), with no dependence on alu_cmt_o_ready.
REQ-022 SHALL keep buf_cnt unchanged on a simultaneous push and pop at buf_cnt=1.
REQ-023 SHALL drive alu_cmt_o_valid = (buf_cnt!=0) && (state!=HALT).
REQ-024 SHALL implement states RUN, EBRK_WAIT, HALT.
REQ-025 SHALL go RUN->EBRK_WAIT on a push with disp_i_ebreak=1; no further push is allowed in EBRK_WAIT.
REQ-026 SHALL go RUN->HALT or EBRK_WAIT->HALT on commit_trap=1; commit_trap takes priority over a same-cycle ebreak push, which is still written.
REQ-027 SHALL keep HALT until reset; in HALT, disp_i_ready=0, alu_cmt_o_valid=0, FIFO contents frozen, disp_halted=1.
REQ-028 SHALL increment cmt_cnt by 1 per pop, wrapping modulo 2^XLEN.
REQ-029 SHALL make alu_cmt_o_* reflect the entry at the read pointer; the payload is don't-care when alu_cmt_o_valid=0.

Reset
REQ-030 SHALL on rst=0 at a clock edge set state=RUN, pointers=0, buf_cnt=0, cmt_cnt=0, alu_cmt_o_valid=0, disp_halted=0.
REQ-031 SHALL drive disp_i_ready=0 during the cycle rst=0 is applied and drive disp_i_ready=1 the first cycle after release.
REQ-032 SHALL discard all buffered entries on reset asserted mid-operation, including in EBRK_WAIT or HALT; no pop and no cmt_cnt increment occurs that cycle.

Verification
REQ-033 SHALL verify: push pc=0x80000000 at cycle 1 with alu_cmt_o_ready=1 -> alu_cmt_o_valid=1 with pc 0x80000000 at cycle 2; cmt_cnt=1 at cycle 3.
REQ-034 SHALL verify: alu_cmt_o_ready=0 and 3 ops offered -> 2 accepted, buf_cnt=2, disp_i_ready=0; ready=1 -> ops drain in order, 2 cycles.
REQ-035 SHALL verify: buf_cnt=1 with simultaneous push and pop for 10 cycles -> buf_cnt stays 1, cmt_cnt +10, order preserved.
REQ-036 SHALL verify: ebreak op accepted -> disp_i_ready=0 next cycle; entry committed, then commit_trap=1 -> disp_halted=1, alu_cmt_o_valid=0 thereafter.
REQ-037 SHALL verify: rst=0 while buf_cnt=2 in HALT -> next cycle buf_cnt=0, cmt_cnt=0, disp_halted=0, disp_i_ready=1 after release.
REQ-038 SHALL verify: cmt_cnt preloaded via 2^32-1 pops (or forced) -> next pop wraps cmt_cnt to 0.
